// File: rtl/imm_gen_pkg.sv
// rtl/imm_gen_pkg.sv - immediate type codes and skid-buffer state encoding for imm_gen_pipe
package imm_gen_pkg;

    localparam int IMM_TYPE_W = 3;

    localparam logic [IMM_TYPE_W-1:0] IMM_I = 3'b000;
    localparam logic [IMM_TYPE_W-1:0] IMM_B = 3'b001;
    localparam logic [IMM_TYPE_W-1:0] IMM_S = 3'b010;
    localparam logic [IMM_TYPE_W-1:0] IMM_U = 3'b011;
    localparam logic [IMM_TYPE_W-1:0] IMM_J = 3'b100;
    localparam logic [IMM_TYPE_W-1:0] IMM_Z = 3'b101;

    // Bit 0 = main entry valid, bit 1 = skid entry valid
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } skid_state_t;

endpackage

// File: rtl/imm_decode_comb.sv
// rtl/imm_decode_comb.sv - combinational immediate format mux and extension; IMM_GEN_ZICSR_EN enables type Z
module imm_decode_comb
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]           instr,
    input  logic [IMM_TYPE_W-1:0] imm_type,
    output logic [XLEN-1:0]       imm,
    output logic                  illegal
);

    logic signed [31:0] raw;
    logic               unused_opcode;

    assign unused_opcode = ^instr[6:0];

    always_comb begin
        raw     = '0;
        illegal = 1'b0;
        case (imm_type)
            IMM_I: raw = {{20{instr[31]}}, instr[31:20]};
            IMM_B: raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_S: raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_U: raw = {instr[31:12], 12'b0};
            IMM_J: raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
`ifdef IMM_GEN_ZICSR_EN
            // Bit 31 stays clear, so the sign extension below acts as zero extension
            IMM_Z: raw = {27'b0, instr[19:15]};
`endif
            default: illegal = 1'b1;
        endcase
    end

    assign imm = XLEN'(raw);

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined immediate generator with two-entry skid buffer and flush
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [IMM_TYPE_W-1:0] in_imm_type,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_imm,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  out_illegal
);

    logic [XLEN-1:0]  dec_imm;
    logic             dec_illegal;
    skid_state_t      state;
    logic [XLEN-1:0]  skid_imm;
    logic [TAG_W-1:0] skid_tag;
    logic             skid_illegal;
    logic             acc;
    logic             pop;

    imm_decode_comb #(
        .XLEN (XLEN)
    ) u_decode (
        .instr    (in_instr),
        .imm_type (in_imm_type),
        .imm      (dec_imm),
        .illegal  (dec_illegal)
    );

    assign acc = in_valid & in_ready;
    assign pop = out_valid & out_ready;

    // out_* registers are the main entry itself; in_ready/out_valid are registered copies of the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_EMPTY;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_imm      <= '0;
            out_tag      <= '0;
            out_illegal  <= 1'b0;
            skid_imm     <= '0;
            skid_tag     <= '0;
            skid_illegal <= 1'b0;
        end else if (flush) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (acc) begin
                        state       <= ST_ONE;
                        out_valid   <= 1'b1;
                        out_imm     <= dec_imm;
                        out_tag     <= in_tag;
                        out_illegal <= dec_illegal;
                    end
                end
                ST_ONE: begin
                    if (acc && !pop) begin
                        state        <= ST_FULL;
                        in_ready     <= 1'b0;
                        skid_imm     <= dec_imm;
                        skid_tag     <= in_tag;
                        skid_illegal <= dec_illegal;
                    end else if (pop && !acc) begin
                        state     <= ST_EMPTY;
                        out_valid <= 1'b0;
                    end else if (acc && pop) begin
                        out_imm     <= dec_imm;
                        out_tag     <= in_tag;
                        out_illegal <= dec_illegal;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state       <= ST_ONE;
                        in_ready    <= 1'b1;
                        out_imm     <= skid_imm;
                        out_tag     <= skid_tag;
                        out_illegal <= skid_illegal;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage of the RV32I core. It accepts instruction words plus an immediate-type code over a valid/ready handshake. It produces the sign- or zero-extended XLEN immediate one cycle later, together with a pass-through tag and an illegal-type flag. A two-entry skid buffer absorbs execute-stage back-pressure without combinational ready paths, and a synchronous flush supports branch redirect.

## Interface
- XLEN, 32: output immediate width; legal values 32 and 64.
- TAG_W, 5: width of the sideband tag carried with each instruction.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous flush; drops all held and incoming entries.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input can be accepted; registered.
- in_instr  in  32  raw instruction word.
- in_imm_type  in  3  immediate format code (package constants).
- in_tag  in  TAG_W  sideband tag, returned unmodified.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts output.
- out_imm  out  XLEN  extracted immediate.
- out_tag  out  TAG_W  tag of the output beat.
- out_illegal  out  1  unsupported type code; out_imm is 0 when set.

## Operation
- Type codes and their outputs (s = sign-extend to XLEN):
  - 000 I: s(instr[31:20]).
  - 001 B: s({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - 010 S: s({instr[31:25], instr[11:7]}).
  - 011 U: s({instr[31:12], 12'b0}).
  - 100 J: s({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - 101 Z: see Configuration.
  - Others: out_imm = 0, out_illegal = 1.
- Extraction is combinational on the input beat. The result is registered into the main entry or the skid entry.
- State machine, encoded by two valid bits:
  - EMPTY: no entries.
  - ONE: main entry valid.
  - FULL: main and skid entries valid.
- Handshake events: acc = in_valid & in_ready; pop = out_valid & out_ready.
- Transitions:
  - EMPTY: on acc, go to ONE.
  - ONE: acc & !pop goes to FULL. pop & !acc goes to EMPTY. acc & pop stays in ONE; main takes the new beat.
  - FULL: on pop, go to ONE; the skid entry moves to main. acc is impossible because in_ready = 0.
- Outputs: in_ready = (state != FULL); out_valid = (state != EMPTY). Output fields always come from the main entry.
- Order is strictly FIFO. No beat is dropped or duplicated except by flush or reset.
- Flush has priority over every other event. At the next edge the state becomes EMPTY. An input beat presented in the flush cycle is discarded, and any pop in that cycle is void.
- Reset (asynchronous, any time, including while FULL):
  - State EMPTY; in_ready = 1; out_valid = 0.
  - out_imm, out_tag and out_illegal all 0.
  - Inputs are ignored while rst_n = 0.

## Timing
- Latency: 1 cycle. A beat accepted at edge n is visible on out_* after edge n.
- Throughput: 1 beat per cycle with continuous out_ready.
- in_ready depends only on registered state, with no out_ready→in_ready combinational path.
- out_* remain stable while out_valid = 1 and out_ready = 0.
- Worst case: out_ready held low for k ≥ 2 cycles with in_valid high stores exactly 2 beats. in_ready falls one cycle after the second accept.

## Configuration
- IMM_GEN_ZICSR_EN
  - Defined: type 101 yields the CSR immediate zero-extended from instr[19:15], with out_illegal = 0.
  - Undefined: type 101 is illegal (out_imm = 0, out_illegal = 1).
  - All other behaviour is identical in both builds.

## Structure
- Package imm_gen_pkg holds:
  - IMM_I, IMM_B, IMM_S, IMM_U, IMM_J, IMM_Z: 3-bit type constants.
  - The IMM_TYPE_W constant.
- The core decoder and ID stage import the type constants from this package.
- One sub-module: imm_decode_comb, the purely combinational format mux and sign-extension (instr, type → imm, illegal). The top holds only the skid buffer and control.

## Test plan
- I-type: instr 0xFFF00093, type 000, tag 3 → next cycle out_imm 0xFFFFFFFF, out_tag 3, out_illegal 0.
- Formats, back-to-back beats with out_ready high, one output per cycle in order:
  - S 0xFE002C23 → 0xFFFFFFF8.
  - B 0xFE000EE3 → 0xFFFFFFFC.
  - U 0x12345037 → 0x12345000.
  - J 0x0010006F → 0x00000800.
- XLEN = 64: the U and B cases above → 0x0000000012345000 and 0xFFFFFFFFFFFFFFFC.
- Back-pressure: out_ready low for 4 cycles while 3 beats are offered.
  - Exactly 2 are accepted; in_ready = 0 until the first pop.
  - Outputs then appear in order with no loss.
- Flush and reset:
  - Flush while FULL with in_valid = 1 → next cycle out_valid 0, in_ready 1, and the offered beat is never output.
  - rst_n pulse low mid-stream → all outputs 0 immediately.
- Illegal and Z codes:
  - Type 111 → out_imm 0, out_illegal 1.
  - Type 101 with instr[19:15] = 0x1F → out_imm 0x1F with IMM_GEN_ZICSR_EN defined; illegal without it.
